// File: rtl/add_seq_if.sv
// Operand/result handshake bundle for the nibble-serial add/subtract sequencer.
// Both sides are strict valid/ready; see add_seq_ctrl for the transfer rules.
interface add_seq_if #(
  parameter int WORDS = 4
) ();
  localparam int W = 4 * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  modport master (
    output in_valid, a, b, cin, op, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, cin, op, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/add_seq_ctrl.sv
// Nibble-serial adder/subtractor: one shared 4-bit ripple slice processes a
// 4*WORDS-bit operation LSB nibble first, one nibble per clock.

module add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic c;

  always_comb begin
    c = ci;
    s = '0;
    for (int i = 0; i < 4; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end
endmodule

module add_seq_ctrl #(
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  add_seq_if.slave    bus,
  output logic [1:0]  dbg_state
);
  localparam int W  = 4 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [IW-1:0] idx;
  logic          carry;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic [W-1:0]  sum_r;
  logic          cout_r;
  logic          ovf_r;

  logic [3:0]    slice_a;
  logic [3:0]    slice_b;
  logic [3:0]    slice_s;
  logic          slice_co;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both 1. Input side is ready only in IDLE; the result is offered only in
  // DONE and held stable until taken. The two never overlap.
  always_comb begin
    slice_a = a_r[{idx, 2'b00} +: 4];
    slice_b = b_r[{idx, 2'b00} +: 4];
  end

  add4 u_slice (
    .a  (slice_a),
    .b  (slice_b),
    .ci (carry),
    .s  (slice_s),
    .co (slice_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx     <= '0;
      carry   <= 1'b0;
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            // Subtraction is a + ~b + 1; the caller's cin is ignored then.
            a_r     <= bus.a;
            b_r     <= bus.op ? ~bus.b : bus.b;
            carry   <= bus.op | bus.cin;
            idx     <= '0;
            sum_r   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_r[{idx, 2'b00} +: 4] <= slice_s;
          carry                    <= slice_co;
          if (idx == LAST) begin
            cout_r  <= slice_co;
            ovf_r   <= (a_r[W-1] == b_r[W-1]) && (slice_s[3] != a_r[W-1]);
            idx     <= '0;
            state_q <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == RUN) || (state_q == DONE);
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.ovf       = ovf_r;
  assign dbg_state     = state_q;
endmodule
